eeprom_i2c_master: RTL

- Byte-level I2C initiator for the 24Cxx-style serial EEPROMs emulated on the cartridge.
- Converts single-byte read/write requests into bit-accurate SCL/SDA waveforms.
- Used to preload or dump EEPROM save contents through the same two-wire interface the game drives.
- Also used as the bench stimulus driver for the EEPROM slave.
- Supports X24C01 addressing (7-bit word address carried in the control byte) and 24C02-style addressing (device byte followed by a word-address byte).

---
 rtl/eeprom_i2c_master.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/eeprom_i2c_master.sv
// Byte-level I2C initiator for 24Cxx-style EEPROMs: turns single-byte read/write
// requests into quarter-bit-timed SCL/SDA waveforms, X24C01 or 24C02 addressing.
module eeprom_i2c_master #(
    parameter int unsigned CLK_DIV = 8,
    parameter int unsigned WR_WAIT = 0
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] MODE,
    input  logic       REQ,
    input  logic       WE,
    input  logic [7:0] ADDR,
    input  logic [7:0] WDATA,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RDATA,
    output logic       NACK,
    output logic       SCL,
    output logic       SDA_O,
    input  logic       SDA_I
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned WW = (WR_WAIT > 1) ? $clog2(WR_WAIT) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [WW-1:0] WT_LAST = WW'(WR_WAIT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_TX_CTRL, S_TX_ADDR, S_TX_DATA, S_RSTART,
        S_TX_CTRL_R, S_RX_DATA, S_STOP, S_WR_WAIT, S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q;
    logic [1:0]    qtr_q;
    logic [3:0]    bit_q;
    logic [WW-1:0] wait_q;
    logic          we_q, m24_q, smp_q, abort_q, nack_q;
    logic [7:0]    addr_q, wdata_q, rx_q, rdata_q;

    logic          slot_end, smp_pt, ack_bad, set_abort, in_slot;
    logic [7:0]    tx_byte;

    always_comb begin
        slot_end = (qtr_q == 2'd3) && (phase_q == PH_LAST);
        smp_pt   = (qtr_q == 2'd3) && (phase_q == '0);
        // with CLK_DIV=1 the sample point and slot end coincide, so bypass the register
        ack_bad  = smp_pt ? SDA_I : smp_q;
        in_slot  = state_q inside {S_START, S_TX_CTRL, S_TX_ADDR, S_TX_DATA, S_RSTART,
                                   S_TX_CTRL_R, S_RX_DATA, S_STOP};

        tx_byte = '1;
        case (state_q)
            S_TX_CTRL:   tx_byte = m24_q ? 8'hA0 : {addr_q[6:0], ~we_q};
            S_TX_ADDR:   tx_byte = addr_q;
            S_TX_DATA:   tx_byte = wdata_q;
            S_TX_CTRL_R: tx_byte = 8'hA1;
            default:     tx_byte = '1;
        endcase

        state_d   = state_q;
        set_abort = 1'b0;
        SCL       = 1'b1;
        SDA_O     = 1'b1;
        BUSY      = !(state_q inside {S_IDLE, S_FINISH});
        DONE      = (state_q == S_FINISH);
        RDATA     = rdata_q;
        NACK      = nack_q;

        case (state_q)
            S_IDLE: begin
                if (REQ) state_d = S_START;
            end
            S_START, S_RSTART: begin
                SCL   = (qtr_q != 2'd3);
                SDA_O = !qtr_q[1];
                if (slot_end) state_d = (state_q == S_START) ? S_TX_CTRL : S_TX_CTRL_R;
            end
            S_TX_CTRL, S_TX_ADDR, S_TX_DATA, S_TX_CTRL_R: begin
                SCL   = qtr_q[1];
                SDA_O = bit_q[3] ? 1'b1 : tx_byte[3'd7 - bit_q[2:0]];
                if (slot_end && bit_q[3]) begin
                    if (ack_bad) begin
                        state_d   = S_STOP;
                        set_abort = 1'b1;
                    end else begin
                        case (state_q)
                            S_TX_CTRL:   state_d = m24_q ? S_TX_ADDR : (we_q ? S_TX_DATA : S_RX_DATA);
                            S_TX_ADDR:   state_d = we_q ? S_TX_DATA : S_RSTART;
                            S_TX_CTRL_R: state_d = S_RX_DATA;
                            default:     state_d = S_STOP;
                        endcase
                    end
                end
            end
            S_RX_DATA: begin
                SCL = qtr_q[1];
                if (slot_end && bit_q[3]) state_d = S_STOP;
            end
            S_STOP: begin
                SCL   = (qtr_q != 2'd0);
                SDA_O = qtr_q[1];
                if (slot_end)
                    state_d = (we_q && !abort_q && (WR_WAIT != 0)) ? S_WR_WAIT : S_FINISH;
            end
            S_WR_WAIT: begin
                if (wait_q == WT_LAST) state_d = S_FINISH;
            end
            S_FINISH: begin
                state_d = S_IDLE;
                NACK    = abort_q;
                if (!we_q && !abort_q) RDATA = rx_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            wait_q  <= '0;
            we_q    <= 1'b0;
            m24_q   <= 1'b0;
            smp_q   <= 1'b1;
            abort_q <= 1'b0;
            nack_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE) begin
                phase_q <= '0;
                qtr_q   <= '0;
                bit_q   <= '0;
                if (REQ) begin
                    we_q    <= WE;
                    m24_q   <= |MODE;
                    addr_q  <= ADDR;
                    wdata_q <= WDATA;
                    abort_q <= 1'b0;
                end
            end else if (in_slot) begin
                phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
                if (phase_q == PH_LAST) qtr_q <= qtr_q + 2'd1;
                // every state change lands on a byte/slot boundary, restarting the bit count
                if (slot_end) bit_q <= (state_d == state_q) ? bit_q + 4'd1 : '0;
                if (smp_pt) smp_q <= SDA_I;
                if (smp_pt && (state_q == S_RX_DATA) && !bit_q[3]) rx_q <= {rx_q[6:0], SDA_I};
                if (set_abort) abort_q <= 1'b1;
            end
            wait_q <= (state_q == S_WR_WAIT) ? wait_q + 1'b1 : '0;
            if (state_q == S_FINISH) begin
                nack_q <= abort_q;
                if (!we_q && !abort_q) rdata_q <= rx_q;
            end
        end
    end

endmodule
